// File: rtl/dla_pkg.sv
// Shared definitions for the systolic-array edge blocks: drain FSM encoding
// and the width helpers used to size result and index buses.
package dla_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  function automatic int acc_width(input int width);
    return 2 * width;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_drain_unit_if.sv
// Result stream from the drain unit toward the result memory writer.
interface result_drain_unit_if
  import dla_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int ACC_W = acc_width(WIDTH);
    localparam int IDX_W = idx_width(N);

    logic [ACC_W-1:0] OUT_DATA;
    logic [IDX_W-1:0] OUT_IDX;
    logic             OUT_VALID;
    logic             OUT_LAST;
    logic             OUT_READY;

    modport master (output OUT_DATA, OUT_IDX, OUT_VALID, OUT_LAST, input OUT_READY);
    modport slave  (input OUT_DATA, OUT_IDX, OUT_VALID, OUT_LAST, output OUT_READY);
endinterface

// File: rtl/result_drain_unit.sv
// Snapshots one PE row's results on DONE, clears the row, and streams the
// snapshot out one result per valid/ready beat.
module result_drain_unit
  import dla_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                              CLK,
    input  logic                              ASYNC_RST,
    input  logic                              DONE,
    input  logic [N*acc_width(WIDTH)-1:0]     PE_RESULTS,
    output logic                              PE_CLR,
    output logic                              BUSY,
    output logic                              OVERRUN,
    result_drain_unit_if.master               out_if
);
    localparam int ACC_W = acc_width(WIDTH);
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_e     state, state_nxt;
    logic [ACC_W-1:0] snapshot [N];
    logic [IDX_W-1:0] idx;
    logic             pe_clr_q;
    logic             overrun_q;

    logic draining, last_beat, xfer, last_xfer, capture;

    assign draining  = (state == ST_DRAIN);
    assign last_beat = (idx == LAST_IDX);
    assign xfer      = draining && out_if.OUT_READY;
    assign last_xfer = xfer && last_beat;
    // A DONE on the final transfer recaptures with no idle bubble.
    assign capture   = DONE && (!draining || last_xfer);

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (DONE) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_xfer && !DONE) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the snapshot is reset along with the rest so OUT_DATA reads 0 out
    // of reset; it is only N words, so the reset fan-out is cheap.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            for (int i = 0; i < N; i++) snapshot[i] <= '0;
            idx       <= '0;
            pe_clr_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            pe_clr_q <= capture;
            if (capture) begin
                for (int i = 0; i < N; i++) snapshot[i] <= PE_RESULTS[i*ACC_W +: ACC_W];
                idx <= '0;
            end else if (xfer) begin
                idx <= last_beat ? '0 : idx + IDX_W'(1);
            end
            if (DONE && draining && !last_xfer) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        out_if.OUT_VALID = 1'b0;
        out_if.OUT_DATA  = '0;
        out_if.OUT_IDX   = '0;
        out_if.OUT_LAST  = 1'b0;
        BUSY             = 1'b0;
        if (draining) begin
            out_if.OUT_VALID = 1'b1;
            out_if.OUT_DATA  = snapshot[idx];
            out_if.OUT_IDX   = idx;
            out_if.OUT_LAST  = last_beat;
            BUSY             = 1'b1;
        end
    end

    assign PE_CLR  = pe_clr_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_result_drain_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized run against a beat-level reference model.
module tb_result_drain_unit;
    import dla_pkg::*;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int ACC_W = 16;
    localparam int IDX_W = 2;
    localparam logic [N*ACC_W-1:0] R_DEF = {16'h1234, 16'hFFFF, 16'h0100, 16'h0001};

    logic CLK = 1'b0;
    logic ASYNC_RST;
    logic DONE;
    logic [N*ACC_W-1:0] PE_RESULTS;
    logic PE_CLR, BUSY, OVERRUN;

    result_drain_unit_if #(.WIDTH(WIDTH), .N(N)) out_if ();

    result_drain_unit #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK        (CLK),
        .ASYNC_RST  (ASYNC_RST),
        .DONE       (DONE),
        .PE_RESULTS (PE_RESULTS),
        .PE_CLR     (PE_CLR),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN),
        .out_if     (out_if)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic v, input logic [15:0] d,
                              input logic [1:0] i, input logic l, input logic clr, input logic busy);
        check({tag, " valid"}, 32'(out_if.OUT_VALID), 32'(v));
        check({tag, " data"},  32'(out_if.OUT_DATA),  32'(d));
        check({tag, " idx"},   32'(out_if.OUT_IDX),   32'(i));
        check({tag, " last"},  32'(out_if.OUT_LAST),  32'(l));
        check({tag, " clr"},   32'(PE_CLR),           32'(clr));
        check({tag, " busy"},  32'(BUSY),             32'(busy));
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change then too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNC_RST = 1'b1;
        DONE = 1'b0;
        out_if.OUT_READY = 1'b0;
        PE_RESULTS = R_DEF;
        tick();
        tick();
        ASYNC_RST = 1'b0;
    endtask

    typedef struct {
        logic        done;
        logic        ready;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ei;
        logic        el;
        logic        eclr;
        logic        ebusy;
    } vec_t;

    vec_t vecs [13];

    // Reference model state: beat-level view of the drain.
    bit          m_busy;
    int          m_pos;
    logic [15:0] m_snap [N];
    bit          m_clr;
    bit          m_ovr;

    initial begin
        // Basic drain, then backpressure on beat 0 for three cycles.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        do_reset();
        check_beat("reset", 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("reset overrun", 32'(OVERRUN), 32'd0);
        out_if.OUT_READY = 1'b1;
        tick();
        check("idle ignores ready", 32'(out_if.OUT_VALID), 32'd0);

        // Table-driven basic drain and backpressure.
        for (int k = 0; k < 13; k++) begin
            DONE = vecs[k].done;
            out_if.OUT_READY = vecs[k].ready;
            tick();
            check_beat($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ed, vecs[k].ei,
                       vecs[k].el, vecs[k].eclr, vecs[k].ebusy);
        end
        DONE = 1'b0;
        check("table overrun", 32'(OVERRUN), 32'd0);

        // Snapshot isolation: inputs change right after capture.
        out_if.OUT_READY = 1'b1;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        PE_RESULTS = {N{16'hAAAA}};
        check_beat("iso b0", 1'b1, 16'h0001, 2'd0, 1'b0, 1'b1, 1'b1);
        tick(); check_beat("iso b1", 1'b1, 16'h0100, 2'd1, 1'b0, 1'b0, 1'b1);
        tick(); check_beat("iso b2", 1'b1, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b1);
        tick(); check_beat("iso b3", 1'b1, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b1);
        tick(); check_beat("iso end", 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Overrun during beat 1, then back-to-back recapture on the last beat.
        PE_RESULTS = R_DEF;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick();
        check_beat("ovr b1", 1'b1, 16'h0100, 2'd1, 1'b0, 1'b0, 1'b1);
        check("ovr before", 32'(OVERRUN), 32'd0);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check_beat("ovr b2", 1'b1, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b1);
        check("ovr set", 32'(OVERRUN), 32'd1);
        tick();
        check_beat("b2b b3", 1'b1, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b1);
        DONE = 1'b1;
        PE_RESULTS = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        tick();
        DONE = 1'b0;
        PE_RESULTS = {N{16'h5555}};
        check_beat("b2b n0", 1'b1, 16'hF00D, 2'd0, 1'b0, 1'b1, 1'b1);
        tick(); check_beat("b2b n1", 1'b1, 16'hCAFE, 2'd1, 1'b0, 1'b0, 1'b1);
        check("ovr sticky", 32'(OVERRUN), 32'd1);
        tick(); check_beat("b2b n2", 1'b1, 16'hBEEF, 2'd2, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of beat 2.
        #2;
        ASYNC_RST = 1'b1;
        #1;
        check("arst valid",   32'(out_if.OUT_VALID), 32'd0);
        check("arst busy",    32'(BUSY),             32'd0);
        check("arst overrun", 32'(OVERRUN),          32'd0);
        check("arst clr",     32'(PE_CLR),           32'd0);
        check("arst data",    32'(out_if.OUT_DATA),  32'd0);
        tick();
        ASYNC_RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_beat($sformatf("post arst %0d", k), 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // Randomized run against the reference model.
        do_reset();
        m_busy = 0; m_pos = 0; m_clr = 0; m_ovr = 0;
        for (int k = 0; k < N; k++) m_snap[k] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic d, r, cap;
            logic [N*ACC_W-1:0] res;
            d   = ($urandom_range(0, 3) == 0);
            r   = 1'($urandom_range(0, 1));
            res = {$urandom, $urandom};
            DONE = d;
            out_if.OUT_READY = r;
            PE_RESULTS = res;

            cap = 1'b0;
            if (!m_busy) begin
                if (d) cap = 1'b1;
            end else if (r && m_pos == N - 1) begin
                if (d) cap = 1'b1;
                else   m_busy = 0;
            end else begin
                if (r) m_pos++;
                if (d) m_ovr = 1;
            end
            m_clr = cap;
            if (cap) begin
                for (int k = 0; k < N; k++) m_snap[k] = res[k*ACC_W +: ACC_W];
                m_pos  = 0;
                m_busy = 1;
            end

            tick();
            check_beat($sformatf("rnd%0d", cyc), m_busy, m_busy ? m_snap[m_pos] : 16'h0,
                       m_busy ? 2'(m_pos) : 2'd0, m_busy && (m_pos == N - 1), m_clr, m_busy);
            check($sformatf("rnd%0d overrun", cyc), 32'(OVERRUN), 32'(m_ovr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_drain_unit.md
Name: result_drain_unit

Overview:
- Reads the accumulated results out of one row of N processing elements once a matrix pass completes.
- Snapshots all N 2*WIDTH-bit results in parallel and pulses a one-cycle clear back to the PE row so the next pass can start.
- Streams the snapshot out one result per beat over a valid/ready interface toward the output buffer.
- Sits between the systolic array row outputs and the result memory writer.

Parameters:
- WIDTH, 8, PE operand width; result width is ACC_W = 2*WIDTH (localparam).
- N, 4, number of PE results per row; N >= 2.
- IDX_W, $clog2(N), width of the beat index output.

Ports:
- CLK  input  1  single clock, rising edge.
- ASYNC_RST  input  1  asynchronous, active-high reset.
- DONE  input  1  one-cycle pulse: the PE row's results are final this cycle.
- PE_RESULTS  input  N*ACC_W  flattened PE results; PE i occupies bits [i*ACC_W +: ACC_W].
- PE_CLR  output  1  one-cycle synchronous clear to the PE row (drives the PE SYNC_RST).
- OUT_DATA  output  ACC_W  current result beat.
- OUT_IDX  output  IDX_W  PE index of the current beat.
- OUT_VALID  output  1  beat valid.
- OUT_LAST  output  1  high with the beat of index N-1.
- OUT_READY  input  1  downstream accepts the beat.
- BUSY  output  1  high while the snapshot is not fully drained.
- OVERRUN  output  1  sticky: DONE arrived while busy and was dropped.

Behaviour:
- Reset (asynchronous, any time including mid-drain):
  - State is IDLE; snapshot registers and index counter are 0.
  - PE_CLR, OUT_VALID, OUT_LAST, BUSY and OVERRUN are 0; OUT_DATA and OUT_IDX are 0.
  - Any partially drained beats are discarded.
- States:
  - IDLE: OUT_VALID=0.
    - DONE=1: capture all N results at this edge, set idx=0, go to DRAIN; PE_CLR=1 for exactly the next cycle.
  - DRAIN: OUT_VALID=1, OUT_DATA=snapshot[idx], OUT_IDX=idx, OUT_LAST=(idx==N-1).
    - Transfer occurs when OUT_VALID and OUT_READY are both high.
    - Transfer with idx<N-1: idx increments.
    - Transfer with idx==N-1 and DONE=0: go to IDLE.
    - Transfer with idx==N-1 and DONE=1 in the same cycle: recapture, idx=0, stay in DRAIN, PE_CLR pulses (back-to-back, no bubble).
- Latency:
  - DONE sampled at edge t → OUT_VALID and PE_CLR high in cycle t+1, carrying beat 0.
  - Minimum drain time is N cycles with OUT_READY held high.
- Handshake:
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_IDX and OUT_LAST hold stable.
  - OUT_VALID never drops before the beat transfers.
  - OUT_READY is ignored in IDLE.
- BUSY = (state==DRAIN). It is registered-state derived, with no combinational path from DONE.
- Overrun: DONE in DRAIN, other than on the last-beat transfer cycle, is ignored and sets OVERRUN=1. OVERRUN clears only on reset.
- PE_CLR:
  - Registered; never high for two consecutive cycles except in back-to-back recaptures.
  - Never asserted by reset itself.
- Data:
  - Snapshot is a straight copy; no arithmetic or truncation.
  - Results are unsigned ACC_W-bit values passed bit-exact.

Decomposition:
- Shared package dla_pkg:
  - drain state encoding (IDLE=0, DRAIN=1).
  - ACC_W derivation helper (2*WIDTH).
  - clog2-based index-width helper shared with the other array-edge blocks.
- No sub-module: the snapshot register array, index counter and two-state FSM are small enough to stay inline.

Test Plan (WIDTH=8, N=4, PE_RESULTS = {0x1234, 0xFFFF, 0x0100, 0x0001} for PE3..PE0 unless stated):
- Basic drain: DONE pulse at cycle 5, OUT_READY=1 → PE_CLR=1 only in cycle 6; beats 0x0001, 0x0100, 0xFFFF, 0x1234 in cycles 6-9 with OUT_IDX 0-3; OUT_LAST only in cycle 9; BUSY low from cycle 10.
- Backpressure: OUT_READY=0 for cycles 6-8, then 1 → OUT_DATA holds 0x0001 with OUT_IDX=0 through cycle 8; all four beats delivered in order, none duplicated or lost.
- Snapshot isolation: change PE_RESULTS to all 0xAAAA the cycle after DONE → drained beats are still the original four values.
- Overrun and back-to-back:
  - DONE during beat 1 → ignored, OVERRUN=1 and sticky.
  - DONE coincident with the beat-3 transfer → new snapshot starts next cycle with OUT_IDX=0, no idle cycle, PE_CLR pulses again.
- Reset mid-drain: assert ASYNC_RST asynchronously during beat 2 → OUT_VALID, BUSY, OVERRUN, PE_CLR drop to 0 immediately; after release, OUT_VALID stays 0 until the next DONE.
